glossy_round_scheduler: RTL and testbench
=========================================

Name: glossy_round_scheduler

Overview:
Periodic round scheduler for the Glossy flooding app. It sits between the top-level sequencer and glossy_app. As initiator, it issues a round-start pulse every T_PERIOD cycles. As receiver, it searches for the first flood, locks its period counter to the received sync indication, and opens a guarded listen window before each expected round. It also exposes slot timing (T_SLOT granularity) and loss-of-sync tracking.

Parameters:
CNT_W, 32, width of period/slot counters
T_PERIOD, 20000000, round period in clk cycles (500 ms at 40 MHz)
T_SLOT, 800000, slot length in clk cycles (20 ms at 40 MHz)
N_SLOTS, 4, slots per round; round length = N_SLOTS*T_SLOT, must be < T_PERIOD - T_GUARD
T_GUARD, 4000, receiver early-listen guard in cycles
MAX_MISS, 3, consecutive missed rounds before the receiver returns to search

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_enable  in  1  level; scheduler runs while high
i_mode  in  1  0 = receiver, 1 = initiator; sampled only on the IDLE exit
i_sync_ind  in  1  single-cycle pulse from glossy_app on first valid RX/TX SFD of a round
o_app_start  out  1  single-cycle pulse; starts a glossy_app round (TX for initiator, listen for receiver)
o_round_active  out  1  high during the round window
o_rx_en  out  1  receiver listen enable (search or guard window or round)
o_slot_tick  out  1  single-cycle pulse at each slot boundary inside a round
o_slot_idx  out  8  current slot index, 0..N_SLOTS-1, 0 outside a round
o_synced  out  1  receiver locked / initiator running
o_miss_cnt  out  8  consecutive missed rounds (saturating at 255)

Behaviour:
- Reset (async): all outputs 0; state IDLE; counters 0; mode register 0.
- States: IDLE, INIT_RUN, RX_SEARCH, RX_SYNCED.
- IDLE: when i_enable=1, latch i_mode. Go to INIT_RUN if the latched mode is 1, else RX_SEARCH. The period counter r_per is set to 0.
- i_enable=0 in any state: next cycle go to IDLE. All outputs clear, counters zeroed, miss count zeroed. This takes priority over every other event.
- r_per counts 0..T_PERIOD-1 and wraps to 0. It runs in INIT_RUN and RX_SYNCED.
- Round window: r_per < N_SLOTS*T_SLOT.
  - o_round_active = 1 in the round window.
  - The slot counter counts 0..T_SLOT-1. On wrap, o_slot_idx increments and o_slot_tick pulses, except on the final wrap at round end.
  - o_slot_idx returns to 0 at round end.
- INIT_RUN:
  - o_app_start pulses on the cycle r_per==0. The first pulse comes 1 cycle after leaving IDLE.
  - o_synced=1.
  - i_sync_ind is ignored.
- RX_SEARCH:
  - o_rx_en=1, o_synced=0.
  - o_app_start pulses once on entry.
  - On i_sync_ind: r_per <= 1 (sync cycle is round cycle 0); slot counter <= 1; go to RX_SYNCED; o_synced=1; miss count <= 0.
- RX_SYNCED:
  - Guard window: r_per >= T_PERIOD-T_GUARD. o_app_start pulses at r_per == T_PERIOD-T_GUARD.
  - o_rx_en = guard window OR round window.
  - i_sync_ind inside guard or round window: re-align as in search (r_per <= 1, slot counter <= 1), mark the round hit, miss count <= 0.
  - i_sync_ind outside those windows is ignored.
  - At the last round cycle (r_per == N_SLOTS*T_SLOT-1) with no hit this period: miss count++.
  - If the new miss count == MAX_MISS: go to RX_SEARCH, o_synced=0, and o_app_start pulses on entry.
- Simultaneous events:
  - i_sync_ind on the last round cycle counts as a hit (no miss increment).
  - A sync re-alignment in the guard window restarts the round immediately; the guard o_app_start is not repeated.
- All outputs are registered; latency from i_sync_ind to o_synced/o_round_active is 1 cycle.

Decomposition:
- Shared package glossy_pkg: state encodings, mode constants (MODE_RX=0, MODE_INIT=1), default timing constants (T_PERIOD, T_SLOT at 40 MHz).
- One sub-module, glossy_slot_timer: slot counter, slot index and tick generation. Inputs are the round-active and realign controls.

Test Plan:
- Initiator, T_PERIOD=100, T_SLOT=10, N_SLOTS=4: enable with i_mode=1 -> o_app_start at cycles 1, 101, 201; o_round_active high 40 cycles each period; o_slot_tick at 10/20/30 into each round; o_slot_idx 0..3.
- Receiver search: i_mode=0, sync pulse at cycle 57 -> o_synced=1 at 58; o_app_start at 57+100-T_GUARD(5)=152; o_rx_en high from 152 through round end.
- Receiver, 3 missed rounds with MAX_MISS=3 -> o_miss_cnt goes 1, 2, 3; then RX_SEARCH, o_synced=0, one o_app_start, o_rx_en=1.
- Receiver drift: sync arrives 3 cycles early inside the guard window -> r_per realigns; next guard o_app_start comes exactly 95 cycles after that sync; o_miss_cnt=0.
- Sync pulse outside the windows while synced -> ignored, no realign, counters unchanged.
- Disable mid-round, or assert reset mid-round -> all outputs 0 on the next cycle (reset: immediately); re-enable restarts from IDLE behaviour.

Source files
------------

// File: rtl/glossy_pkg.sv
// Shared types and default timing for the Glossy round scheduler (40 MHz clock).
// Pure definitions: no logic, no latency, no flow control.
package glossy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INIT_RUN  = 2'd1,
        ST_RX_SEARCH = 2'd2,
        ST_RX_SYNCED = 2'd3
    } state_e;

    localparam logic MODE_RX   = 1'b0;
    localparam logic MODE_INIT = 1'b1;

    localparam int DEF_CNT_W    = 32;
    localparam int DEF_T_PERIOD = 20000000;
    localparam int DEF_T_SLOT   = 800000;
    localparam int DEF_N_SLOTS  = 4;
    localparam int DEF_T_GUARD  = 4000;
    localparam int DEF_MAX_MISS = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/glossy_round_scheduler_if.sv
// Control/status bundle between the sequencer (master) and the round scheduler (slave).
// Level and single-cycle pulse signals only; no handshake.
interface glossy_round_scheduler_if;
    logic       i_enable;
    logic       i_mode;
    logic       i_sync_ind;
    logic       o_app_start;
    logic       o_round_active;
    logic       o_rx_en;
    logic       o_slot_tick;
    logic [7:0] o_slot_idx;
    logic       o_synced;
    logic [7:0] o_miss_cnt;

    modport master (
        output i_enable, i_mode, i_sync_ind,
        input  o_app_start, o_round_active, o_rx_en, o_slot_tick,
        input  o_slot_idx, o_synced, o_miss_cnt
    );

    modport slave (
        input  i_enable, i_mode, i_sync_ind,
        output o_app_start, o_round_active, o_rx_en, o_slot_tick,
        output o_slot_idx, o_synced, o_miss_cnt
    );
endinterface

// File: rtl/glossy_slot_timer.sv
// Slot counter, slot index and boundary tick inside a round window.
// Inputs describe the next cycle, so outputs line up with the round counter; no backpressure.
module glossy_slot_timer #(
    parameter int CNT_W  = 32,
    parameter int T_SLOT = 800000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_round,
    input  logic       i_start,
    input  logic       i_realign,
    output logic       o_slot_tick,
    output logic [7:0] o_slot_idx
);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(T_SLOT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        idx_d  = idx_q;
        tick_d = 1'b0;
        if (!i_round) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (i_realign) begin
            // The sync cycle itself was slot cycle 0.
            cnt_d = CNT_W'(1);
            idx_d = '0;
        end else if (i_start) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == SLOT_LAST) begin
            cnt_d  = '0;
            idx_d  = idx_q + 8'd1;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            tick_q <= tick_d;
        end
    end

    assign o_slot_tick = tick_q;
    assign o_slot_idx  = idx_q;
endmodule

// File: rtl/glossy_round_scheduler.sv
// Periodic Glossy round scheduler: initiator period generator or receiver sync tracker.
// All outputs registered; i_sync_ind reaches o_synced/o_round_active one cycle later; no backpressure.
module glossy_round_scheduler
    import glossy_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int T_PERIOD = DEF_T_PERIOD,
    parameter int T_SLOT   = DEF_T_SLOT,
    parameter int N_SLOTS  = DEF_N_SLOTS,
    parameter int T_GUARD  = DEF_T_GUARD,
    parameter int MAX_MISS = DEF_MAX_MISS
) (
    input  logic                     clk,
    input  logic                     reset,
    glossy_round_scheduler_if.slave  sif
);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(T_PERIOD - 1);
    localparam logic [CNT_W-1:0] ROUND_LEN   = CNT_W'(N_SLOTS * T_SLOT);
    localparam logic [CNT_W-1:0] ROUND_LAST  = CNT_W'(N_SLOTS * T_SLOT - 1);
    localparam logic [CNT_W-1:0] GUARD_START = CNT_W'(T_PERIOD - T_GUARD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] per_q, per_d, per_inc;
    logic             hit_q, hit_d;
    logic [7:0]       miss_q, miss_d;
    logic             app_start_q, app_start_d;
    logic             round_q, round_d;
    logic             rx_en_q, rx_en_d;
    logic             synced_q, synced_d;
    logic             in_window, realign, guard_d, slot_start;

    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        realign   = 1'b0;
        per_inc   = (per_q == PERIOD_LAST) ? '0 : per_q + 1'b1;
        in_window = (per_q < ROUND_LEN) || (per_q >= GUARD_START);

        if (!sif.i_enable) begin
            state_d = ST_IDLE;
            per_d   = '0;
            hit_d   = 1'b0;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    per_d   = '0;
                    state_d = (sif.i_mode == MODE_INIT) ? ST_INIT_RUN : ST_RX_SEARCH;
                end
                ST_INIT_RUN: per_d = per_inc;
                ST_RX_SEARCH: begin
                    if (sif.i_sync_ind) begin
                        state_d = ST_RX_SYNCED;
                        per_d   = CNT_W'(1);
                        realign = 1'b1;
                        hit_d   = 1'b1;
                        miss_d  = '0;
                    end
                end
                ST_RX_SYNCED: begin
                    per_d = per_inc;
                    // A sync on the last round cycle wins over the miss check.
                    if (sif.i_sync_ind && in_window) begin
                        per_d   = CNT_W'(1);
                        realign = 1'b1;
                        hit_d   = 1'b1;
                        miss_d  = '0;
                    end else if (per_q == ROUND_LAST) begin
                        hit_d = 1'b0;
                        if (!hit_q) begin
                            miss_d = sat_inc8(miss_q);
                            if (miss_d == 8'(MAX_MISS)) begin
                                state_d = ST_RX_SEARCH;
                                per_d   = '0;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are derived from next-cycle values so they coincide with per_q.
        round_d     = ((state_d == ST_INIT_RUN) || (state_d == ST_RX_SYNCED)) && (per_d < ROUND_LEN);
        guard_d     = (state_d == ST_RX_SYNCED) && (per_d >= GUARD_START);
        rx_en_d     = (state_d == ST_RX_SEARCH) || (state_d == ST_RX_SYNCED && (round_d || guard_d));
        synced_d    = (state_d == ST_INIT_RUN) || (state_d == ST_RX_SYNCED);
        slot_start  = (per_d == '0);
        app_start_d = ((state_q != ST_RX_SEARCH) && (state_d == ST_RX_SEARCH)) ||
                      ((state_d == ST_INIT_RUN)  && (per_d == '0)) ||
                      ((state_d == ST_RX_SYNCED) && (per_d == GUARD_START));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            per_q       <= '0;
            hit_q       <= 1'b0;
            miss_q      <= '0;
            app_start_q <= 1'b0;
            round_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            synced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            app_start_q <= app_start_d;
            round_q     <= round_d;
            rx_en_q     <= rx_en_d;
            synced_q    <= synced_d;
        end
    end

    glossy_slot_timer #(
        .CNT_W  (CNT_W),
        .T_SLOT (T_SLOT)
    ) u_slot_timer (
        .clk         (clk),
        .reset       (reset),
        .i_round     (round_d),
        .i_start     (slot_start),
        .i_realign   (realign),
        .o_slot_tick (sif.o_slot_tick),
        .o_slot_idx  (sif.o_slot_idx)
    );

    assign sif.o_app_start    = app_start_q;
    assign sif.o_round_active = round_q;
    assign sif.o_rx_en        = rx_en_q;
    assign sif.o_synced       = synced_q;
    assign sif.o_miss_cnt     = miss_q;
endmodule

// File: tb/tb_glossy_round_scheduler.sv
// Directed bench for glossy_round_scheduler with a short period (100 cycles, 4x10-cycle slots, guard 5).
// Expected outputs come from hand-written per-cycle formulas and event tables.
module tb_glossy_round_scheduler;
    localparam int TP = 100;
    localparam int TS = 10;
    localparam int NS = 4;
    localparam int TG = 5;
    localparam int MM = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    glossy_round_scheduler_if sif();

    glossy_round_scheduler #(
        .CNT_W    (32),
        .T_PERIOD (TP),
        .T_SLOT   (TS),
        .N_SLOTS  (NS),
        .T_GUARD  (TG),
        .MAX_MISS (MM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic app, input logic rnd, input logic rx,
                                         input logic tk, input logic syn,
                                         input logic [7:0] idx, input logic [7:0] miss);
        return {11'd0, app, rnd, rx, tk, syn, idx, miss};
    endfunction

    function automatic logic [31:0] outs();
        return pack(sif.o_app_start, sif.o_round_active, sif.o_rx_en, sif.o_slot_tick,
                    sif.o_synced, sif.o_slot_idx, sif.o_miss_cnt);
    endfunction

    // Initiator: round cycle 0 is bench cycle 1.
    function automatic logic [31:0] exp_init(input int k);
        int   p;
        logic rnd;
        p   = (k - 1) % TP;
        rnd = (p < NS * TS);
        return pack(p == 0, rnd, 1'b0, rnd && (p % TS == 0) && (p != 0), 1'b1,
                    rnd ? 8'(p / TS) : 8'd0, 8'd0);
    endfunction

    // Receiver event table: syncs at 57 (lock), 254 (3 early in guard), 300 (outside windows),
    // three silent rounds to cycle 593 (back to search), 620 (relock), 659 (last round cycle).
    function automatic logic [7:0] exp_miss(input int k);
        if (k < 197)  return 8'd0;
        if (k <= 254) return 8'd1;
        if (k <= 393) return 8'd0;
        if (k <= 493) return 8'd1;
        if (k <= 593) return 8'd2;
        if (k <= 620) return 8'd3;
        return 8'd0;
    endfunction

    function automatic logic [31:0] exp_rx(input int k);
        int   anc;
        int   p;
        logic rnd;
        logic grd;
        if (k <= 57 || (k >= 594 && k <= 620))
            return pack(k == 1 || k == 594, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, exp_miss(k));
        if (k <= 254)      anc = 57;
        else if (k <= 593) anc = 254;
        else if (k <= 659) anc = 620;
        else               anc = 659;
        p   = (k - anc) % TP;
        rnd = (p < NS * TS);
        grd = (p >= TP - TG);
        return pack(p == TP - TG, rnd, rnd | grd, rnd && (p % TS == 0) && (p != 0), 1'b1,
                    rnd ? 8'(p / TS) : 8'd0, exp_miss(k));
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset          = 1'b1;
        sif.i_enable   = 1'b0;
        sif.i_mode     = 1'b0;
        sif.i_sync_ind = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_state", outs(), 32'd0);
        reset = 1'b0;
        next_cyc();

        // Initiator run, then disable in the middle of a round.
        cyc          = 0;
        sif.i_enable = 1'b1;
        sif.i_mode   = 1'b1;
        while (cyc < 214) begin
            next_cyc();
            check_eq("init", outs(), exp_init(cyc));
        end
        sif.i_enable = 1'b0;
        next_cyc();
        check_eq("disable_mid_round", outs(), 32'd0);
        repeat (3) next_cyc();
        check_eq("idle", outs(), 32'd0);

        // Restart from IDLE, then async reset mid-round.
        cyc          = 0;
        sif.i_enable = 1'b1;
        while (cyc < 15) begin
            next_cyc();
            check_eq("init_restart", outs(), exp_init(cyc));
        end
        reset = 1'b1;
        #1;
        check_eq("async_reset", outs(), 32'd0);
        sif.i_enable = 1'b0;
        next_cyc();
        reset = 1'b0;
        next_cyc();

        // Receiver scenario.
        cyc          = 0;
        sif.i_enable = 1'b1;
        sif.i_mode   = 1'b0;
        while (cyc < 700) begin
            next_cyc();
            check_eq("rx", outs(), exp_rx(cyc));
            sif.i_sync_ind = (cyc == 57) || (cyc == 254) || (cyc == 300) ||
                             (cyc == 620) || (cyc == 659);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
